// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable sequencer: debounced single-step or divided free-run with
// optional break on the ALU zero flag; reports pulse count and state.
module cpu_step_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned RUN_DIV         = 50000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        BTN_STEP,
   input  logic        SW_RUN,
   input  logic        SW_BRK,
   input  logic        BRK_IN,
   output logic        CPU_CE,
   output logic [15:0] STEP_CNT,
   output logic [1:0]  STATE
);

   localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned DivW = $clog2(RUN_DIV);
   localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYCLES);
   localparam logic [DivW-1:0] DivMax = DivW'(RUN_DIV - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StStep = 2'd1,
      StRun  = 2'd2,
      StHalt = 2'd3
   } state_e;

   // Bit 0 = step button, bit 1 = run switch, bit 2 = break switch.
   logic [2:0]     raw;
   logic [2:0]     sync1_q, sync2_q, db_q;
   logic [DbW-1:0] db_cnt_q [3];
   logic           btn_prev_q;
   logic           step_req, run_db, brk_db;

   state_e          state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic            cpu_ce_q, ce_d;
   logic            ce_prev_q;
   logic [15:0]     step_cnt_q;

   assign raw = {SW_BRK, SW_RUN, BTN_STEP};

   // Level is accepted on the cycle after DEBOUNCE_CYCLES consecutive mismatches.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         db_q       <= '0;
         btn_prev_q <= 1'b0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         btn_prev_q <= db_q[0];
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DbMax) begin
               db_q[i]     <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   assign step_req = db_q[0] & ~btn_prev_q;
   assign run_db   = db_q[1];
   assign brk_db   = db_q[2];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StIdle;
         div_q      <= '0;
         cpu_ce_q   <= 1'b0;
         ce_prev_q  <= 1'b0;
         step_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         cpu_ce_q   <= ce_d;
         ce_prev_q  <= cpu_ce_q;
         step_cnt_q <= step_cnt_q + {15'd0, cpu_ce_q};
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (run_db)        state_d = StRun;
            else if (step_req) state_d = StStep;
         end
         StStep: state_d = StIdle;
         StRun: begin
            if (!run_db)                            state_d = StIdle;
            else if (ce_prev_q && brk_db && BRK_IN) state_d = StHalt;
         end
         StHalt: begin
            if (!run_db) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are computed from the next state so they register alongside it.
   always_comb begin
      ce_d  = 1'b0;
      div_d = '0;
      if (state_d == StStep) begin
         ce_d = 1'b1;
      end else if (state_q == StRun && state_d == StRun) begin
         ce_d  = (div_q == DivMax);
         div_d = (div_q == DivMax) ? '0 : div_q + DivW'(1);
      end
   end

   assign CPU_CE   = cpu_ce_q;
   assign STEP_CNT = step_cnt_q;
   assign STATE    = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=8.
module tb_cpu_step_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        BTN_STEP, SW_RUN, SW_BRK, BRK_IN;
   logic        CPU_CE;
   logic [15:0] STEP_CNT;
   logic [1:0]  STATE;

   int n_checks = 0;
   int n_fails  = 0;
   int pulses   = 0;
   int base;

   cpu_step_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .RUN_DIV        (8)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .BTN_STEP(BTN_STEP),
      .SW_RUN  (SW_RUN),
      .SW_BRK  (SW_BRK),
      .BRK_IN  (BRK_IN),
      .CPU_CE  (CPU_CE),
      .STEP_CNT(STEP_CNT),
      .STATE   (STATE)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (CPU_CE === 1'b1) pulses <= pulses + 1;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      RST = 1'b1; BTN_STEP = 1'b0; SW_RUN = 1'b0; SW_BRK = 1'b0; BRK_IN = 1'b0;
      repeat (3) tick();
      chk("rst_ce", 32'(CPU_CE), 0);
      chk("rst_cnt", 32'(STEP_CNT), 0);
      chk("rst_state", 32'(STATE), 0);
      RST = 1'b0;
      base = pulses;
      repeat (50) tick();
      chk("idle_pulses", 32'(pulses - base), 0);
      chk("idle_cnt", 32'(STEP_CNT), 0);
      chk("idle_state", 32'(STATE), 0);

      // Single step: press set up before edge k, pulse at k+7
      base = pulses;
      BTN_STEP = 1'b1;
      repeat (7) tick();
      chk("step_early_ce", 32'(CPU_CE), 0);
      chk("step_early_state", 32'(STATE), 0);
      tick();
      chk("step_ce", 32'(CPU_CE), 1);
      chk("step_state", 32'(STATE), 1);
      tick();
      chk("step_ce_off", 32'(CPU_CE), 0);
      chk("step_back_idle", 32'(STATE), 0);
      chk("step_cnt", 32'(STEP_CNT), 1);
      repeat (11) tick();
      BTN_STEP = 1'b0;
      repeat (15) tick();
      chk("step_one_pulse", 32'(pulses - base), 1);

      // Bounce rejection
      base = pulses;
      for (int i = 0; i < 15; i++) begin
         BTN_STEP = ~BTN_STEP;
         repeat (2) tick();
      end
      BTN_STEP = 1'b0;
      repeat (15) tick();
      chk("bounce_none", 32'(pulses - base), 0);
      for (int i = 0; i < 6; i++) begin
         BTN_STEP = ~BTN_STEP;
         repeat (2) tick();
      end
      BTN_STEP = 1'b1;
      repeat (20) tick();
      BTN_STEP = 1'b0;
      repeat (15) tick();
      chk("bounce_then_hold", 32'(pulses - base), 1);
      chk("bounce_cnt", 32'(STEP_CNT), 2);

      // Run and stop
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tick();
      chk("run_pre_cnt", 32'(STEP_CNT), 0);
      base = pulses;
      SW_RUN = 1'b1;
      repeat (8) tick();
      chk("run_enter", 32'(STATE), 2);
      chk("run_enter_ce", 32'(CPU_CE), 0);
      repeat (7) tick();
      chk("run_k14_ce", 32'(CPU_CE), 0);
      tick();
      chk("run_p1", 32'(CPU_CE), 1);
      repeat (8) tick();
      chk("run_p2", 32'(CPU_CE), 1);
      repeat (8) tick();
      chk("run_p3", 32'(CPU_CE), 1);
      SW_RUN = 1'b0;
      repeat (7) tick();
      chk("run_stop_late", 32'(STATE), 2);
      tick();
      chk("run_stop", 32'(STATE), 0);
      repeat (20) tick();
      chk("run_pulses", 32'(pulses - base), 3);
      chk("run_cnt", 32'(STEP_CNT), 3);

      // Break on the cycle after the second pulse
      SW_BRK = 1'b1;
      repeat (10) tick();
      base = pulses;
      SW_RUN = 1'b1;
      repeat (8) tick();
      chk("brk_enter", 32'(STATE), 2);
      repeat (8) tick();
      chk("brk_p1", 32'(CPU_CE), 1);
      repeat (8) tick();
      chk("brk_p2", 32'(CPU_CE), 1);
      tick();
      BRK_IN = 1'b1;
      chk("brk_sample_state", 32'(STATE), 2);
      tick();
      BRK_IN = 1'b0;
      chk("brk_halt", 32'(STATE), 3);
      chk("brk_halt_ce", 32'(CPU_CE), 0);
      repeat (30) tick();
      chk("brk_no_p3", 32'(pulses - base), 2);
      chk("brk_still_halt", 32'(STATE), 3);
      SW_RUN = 1'b0;
      repeat (7) tick();
      chk("brk_exit_late", 32'(STATE), 3);
      tick();
      chk("brk_exit", 32'(STATE), 0);
      chk("brk_cnt", 32'(STEP_CNT), 5);
      SW_BRK = 1'b0;

      // Counter wrap from 0xFFFF
      RST = 1'b1;
      tick();
      RST = 1'b0;
      repeat (10) tick();
      @(negedge CLK);
      force dut.step_cnt_q = 16'hFFFF;
      #1;
      release dut.step_cnt_q;
      tick();
      chk("wrap_preload", 32'(STEP_CNT), 32'h0000_FFFF);
      BTN_STEP = 1'b1;
      repeat (8) tick();
      chk("wrap_ce", 32'(CPU_CE), 1);
      tick();
      chk("wrap_cnt", 32'(STEP_CNT), 0);
      BTN_STEP = 1'b0;
      repeat (15) tick();

      // Reset during a run pulse
      SW_RUN = 1'b1;
      repeat (8) tick();
      repeat (8) tick();
      chk("mid_p1", 32'(CPU_CE), 1);
      repeat (8) tick();
      chk("mid_p2", 32'(CPU_CE), 1);
      chk("mid_cnt", 32'(STEP_CNT), 1);
      RST = 1'b1;
      #1;
      chk("mid_rst_ce", 32'(CPU_CE), 0);
      chk("mid_rst_state", 32'(STATE), 0);
      chk("mid_rst_cnt", 32'(STEP_CNT), 0);
      SW_RUN = 1'b0;
      repeat (3) tick();
      RST = 1'b0;
      base = pulses;
      repeat (20) tick();
      chk("post_rst_pulses", 32'(pulses - base), 0);
      chk("post_rst_state", 32'(STATE), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
